timer_dev: RTL and testbench
============================

Name: timer_dev

Overview:
Memory-mapped countdown timer on the device side of the processor I/O bridge.
- Responds to the bridge's word-addressed register reads and writes.
- Raises an interrupt request that the bridge forwards on one HWInt line.
- The CPU writes PRESET and CTRL; the device counts down, then interrupts once (one-shot) or periodically (auto-reload).

Parameters:
DW, 32, data width of registers and bus.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-low reset.
Addr  input  2  register word select, bus address bits [3:2].
WE  input  1  write strobe from bridge, sampled on rising clk.
DIN  input  DW  write data from bridge.
DOUT  output  DW  read data, combinational from Addr.
IRQ  output  1  interrupt request to bridge (HWInt bit).

Behaviour:
Register map:
- Addr 0: CTRL. Bit0 En, bits2:1 Mode, bit3 IM; other bits read 0.
- Addr 1: PRESET, read/write.
- Addr 2: COUNT, read-only; writes ignored.
- Addr 3: reserved; reads 0, writes ignored.

Bus timing:
- Reads have zero latency: DOUT = mux(Addr) of current register values.
- Writes take effect at the clk edge where WE=1.
- A write to CTRL loads bits 3:0 only.
- Any CTRL write clears pending.

Reset (rst=0, asynchronous):
- CTRL=0, PRESET=0, COUNT=0, pending=0, state=IDLE.
- DOUT follows Addr, so it reads 0 for every Addr.
- IRQ=0.

Modes:
- Mode 1: auto-reload.
- Modes 0, 2, 3: one-shot.

FSM states IDLE, LOAD, CNT, INT; one transition per edge:
- IDLE: if En=1 -> LOAD.
- LOAD: COUNT<=PRESET; -> CNT. If En=0 -> IDLE.
- CNT, En=0: -> IDLE; COUNT holds.
- CNT, COUNT>1: COUNT<=COUNT-1.
- CNT, COUNT<=1: COUNT<=0, pending<=1, -> INT.
- INT, one-shot: hardware clears En; -> IDLE; pending stays set until a CTRL write.
- INT, auto-reload: pending<=0; -> LOAD.

Output:
- IRQ = pending & IM.
- In auto-reload, IRQ is therefore a 1-cycle pulse.

Latency:
- Enabling write at edge E0 puts INT at edge E(P+2) for PRESET=P>=1.
- For P=0, INT is at E3.
- Auto-reload period is P+2 cycles for P>=1, and 3 cycles for P=0.

Priorities and boundaries:
- CPU CTRL write vs. same-edge hardware En-clear in INT: CPU write wins.
- Hardware pending-set vs. same-edge CTRL write clear: pending-set wins.
- PRESET write during CNT: no effect on COUNT; used at the next LOAD.
- En=0 written mid-count: stops the count, COUNT frozen. Re-enabling reloads from PRESET.
- COUNT never wraps below 0.
- PRESET=0xFFFFFFFF is legal and counts fully.
- Reset asserted mid-count: immediate return to reset values, IRQ drops asynchronously.

Test Plan:
- Reset, read Addr 0..3 -> DOUT=0 for all; IRQ=0; write Addr 2 = 5 -> COUNT still 0.
- PRESET=3, CTRL=0x9 (En, one-shot, IM) at E0 -> COUNT reads 3,2,1 on E2..E4; IRQ rises after E5 and stays high; CTRL reads 0x8. Write CTRL=0 -> IRQ low next edge.
- PRESET=2, CTRL=0xB (auto-reload, IM) -> IRQ 1-cycle pulses every 4 cycles for at least 5 periods; change PRESET to 4 mid-count -> period becomes 6 starting from the following reload.
- CTRL=0x1 (IM=0), PRESET=1 -> count completes and pending sets internally, but IRQ stays 0. Then write CTRL=0x8 -> pending cleared, IRQ stays 0.
- PRESET=10 in one-shot; write CTRL=0x8 (En=0) at COUNT=6 -> COUNT holds 6 for 5 cycles, no IRQ. Re-enable -> COUNT reloads 10, IRQ after 12 cycles.
- Edge cases:
  - PRESET=0 one-shot -> IRQ after E3.
  - Assert rst while IRQ=1 -> IRQ, CTRL, COUNT go 0 without a clock.
  - CTRL write on the INT edge -> CPU value retained, IRQ set.

Source files
------------

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer for the I/O bridge: CTRL/PRESET/COUNT registers,
// one-shot or auto-reload countdown, and a single maskable interrupt request.
module timer_dev #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    Addr,
    input  logic          WE,
    input  logic [DW-1:0] DIN,
    output logic [DW-1:0] DOUT,
    output logic          IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    ctrl_q, ctrl_d;
    logic [DW-1:0] preset_q, preset_d;
    logic [DW-1:0] count_q, count_d;
    logic          pending_q, pending_d;
    logic          irq_q, irq_d;

    logic wr_ctrl;
    logic wr_preset;
    logic en;
    logic auto_reload;

    assign wr_ctrl     = WE && (Addr == 2'd0);
    assign wr_preset   = WE && (Addr == 2'd1);
    assign en          = ctrl_q[0];
    assign auto_reload = (ctrl_q[2:1] == 2'b01);

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;

        if (wr_preset) begin
            preset_d = DIN;
        end

        // Bus clear comes first so a same-edge hardware pending-set overrides it.
        if (wr_ctrl) begin
            pending_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else begin
                    count_d = preset_q;
                    state_d = S_CNT;
                end
            end
            S_CNT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (count_q > DW'(1)) begin
                    count_d = count_q - DW'(1);
                end else begin
                    count_d   = '0;
                    pending_d = 1'b1;
                    state_d   = S_INT;
                end
            end
            S_INT: begin
                if (auto_reload) begin
                    pending_d = 1'b0;
                    state_d   = S_LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bus write applied last so the CPU value beats the hardware En-clear.
        if (wr_ctrl) begin
            ctrl_d = DIN[3:0];
        end

        irq_d = pending_d & ctrl_d[3];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        DOUT = '0;
        unique case (Addr)
            2'd0:    DOUT = {{(DW-4){1'b0}}, ctrl_q};
            2'd1:    DOUT = preset_q;
            2'd2:    DOUT = count_q;
            default: DOUT = '0;
        endcase
    end

    assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: register map, one-shot/auto-reload timing,
// masking, pause/resume, reset and same-edge priority cases.
module tb_timer_dev;

    logic        clk;
    logic        rst;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DIN;
    logic [31:0] DOUT;
    logic        IRQ;

    int checks;
    int errors;

    timer_dev #(.DW(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .Addr (Addr),
        .WE   (WE),
        .DIN  (DIN),
        .DOUT (DOUT),
        .IRQ  (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        DIN  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input string tag);
        Addr = a;
        #1;
        chk(tag, DOUT, e);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b0;
        Addr = 2'd0;
        WE   = 1'b0;
        DIN  = '0;

        // Reset values
        #12;
        rd(2'd0, 32'h0, "rst_ctrl");
        rd(2'd1, 32'h0, "rst_preset");
        rd(2'd2, 32'h0, "rst_count");
        rd(2'd3, 32'h0, "rst_rsvd");
        chk("rst_irq", IRQ, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        wr(2'd2, 32'd5);
        rd(2'd2, 32'h0, "count_ro");
        wr(2'd3, 32'd7);
        rd(2'd3, 32'h0, "rsvd_ro");
        rd(2'd1, 32'h0, "preset_untouched");

        // One-shot, PRESET=3
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        rd(2'd0, 32'h9, "os_ctrl_wr");
        step();
        step(); rd(2'd2, 32'd3, "os_cnt_e2");
        step(); rd(2'd2, 32'd2, "os_cnt_e3");
        step(); rd(2'd2, 32'd1, "os_cnt_e4");
        chk("os_irq_e4", IRQ, 1'b0);
        step(); chk("os_irq_e5", IRQ, 1'b1);
        rd(2'd2, 32'd0, "os_cnt_e5");
        step(); rd(2'd0, 32'h8, "os_en_clr");
        chk("os_irq_e6", IRQ, 1'b1);
        step(); chk("os_irq_e7", IRQ, 1'b1);
        rd(2'd2, 32'd0, "os_no_wrap");
        wr(2'd0, 32'h0);
        chk("os_irq_clr", IRQ, 1'b0);

        // Auto-reload, PRESET=2 then 4
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 22; k++) begin
            step();
            chk($sformatf("ar_irq_%0d", k), IRQ, (k % 4 == 0));
        end
        rd(2'd2, 32'd2, "ar_cnt_e22");
        wr(2'd1, 32'd4);
        rd(2'd2, 32'd1, "ar_preset_no_effect");
        chk("ar_irq_23", IRQ, 1'b0);
        for (int k = 24; k <= 37; k++) begin
            step();
            chk($sformatf("ar6_irq_%0d", k), IRQ, (k == 24 || k == 30 || k == 36));
            if (k == 26) rd(2'd2, 32'd4, "ar_reload4");
        end
        wr(2'd0, 32'h0);
        step();

        // IM=0 masks the request; CTRL write clears pending
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("mask_irq_%0d", k), IRQ, 1'b0);
            if (k == 2) rd(2'd2, 32'd1, "mask_cnt");
        end
        rd(2'd0, 32'h0, "mask_en_clr");
        wr(2'd0, 32'h8);
        chk("mask_pend_clr", IRQ, 1'b0);
        step(); chk("mask_pend_clr2", IRQ, 1'b0);

        // Pause mid-count, then resume from PRESET
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 5; k++) step();
        rd(2'd2, 32'd7, "pause_cnt_e5");
        wr(2'd0, 32'h8);
        rd(2'd2, 32'd6, "pause_cnt_e6");
        for (int k = 1; k <= 5; k++) begin
            step();
            rd(2'd2, 32'd6, $sformatf("pause_hold_%0d", k));
            chk($sformatf("pause_irq_%0d", k), IRQ, 1'b0);
        end
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 2) rd(2'd2, 32'd10, "resume_reload");
            chk($sformatf("resume_irq_%0d", k), IRQ, (k == 12));
        end
        wr(2'd0, 32'h0);
        chk("resume_irq_clr", IRQ, 1'b0);

        // CTRL write on the pending-set edge, then async reset with IRQ high
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        step(); step(); step();
        rd(2'd2, 32'd1, "pe_cnt_e3");
        wr(2'd0, 32'h9);
        chk("pe_irq_set", IRQ, 1'b1);
        rd(2'd0, 32'h9, "pe_ctrl_cpu");
        step();
        rd(2'd0, 32'h8, "pe_en_clr");
        chk("pe_irq_hold", IRQ, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_irq", IRQ, 1'b0);
        rd(2'd0, 32'h0, "arst_ctrl");
        rd(2'd1, 32'h0, "arst_preset");
        rd(2'd2, 32'h0, "arst_count");
        @(negedge clk);
        rst = 1'b1;

        // CTRL write on the INT edge beats the hardware En-clear
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        step(); step();
        rd(2'd2, 32'd1, "int_cnt_e2");
        step(); chk("int_irq_e3", IRQ, 1'b1);
        wr(2'd0, 32'h9);
        rd(2'd0, 32'h9, "int_cpu_wins");
        chk("int_pend_clr", IRQ, 1'b0);
        step(); step();
        rd(2'd2, 32'd1, "int_restart_cnt");
        step(); chk("int_restart_irq", IRQ, 1'b1);
        wr(2'd0, 32'h0);

        // PRESET=0 one-shot
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        step();
        step(); chk("p0_irq_e2", IRQ, 1'b0);
        rd(2'd2, 32'd0, "p0_cnt_e2");
        step(); chk("p0_irq_e3", IRQ, 1'b1);
        wr(2'd0, 32'h0);
        chk("p0_irq_clr", IRQ, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
